// File: rtl/prim_ram_1p_adv.sv
// Single-port synchronous RAM with per-lane write mask and optional input/output register stages.
// Reads return data at a fixed latency of 1 + EnableInputPipeline + EnableOutputPipeline cycles.
module prim_ram_1p_adv #(
    parameter int Depth                = 16,
    parameter int Width                = 32,
    parameter int DataBitsPerMask      = 1,
    parameter int EnableInputPipeline  = 0,
    parameter int EnableOutputPipeline = 0,
    localparam int Aw                  = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             write_i,
    input  logic [Aw-1:0]    addr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Width-1:0] wmask_i,
    output logic [Width-1:0] rdata_o,
    output logic             rvalid_o,
    output logic [1:0]       rerror_o,
    input  logic [9:0]       cfg_i
);

    localparam int Lanes = Width / DataBitsPerMask;
    localparam logic [Aw:0] DepthW = (Aw + 1)'(Depth);

    if (Width % DataBitsPerMask != 0) begin : g_bad_mask
        $fatal(1, "prim_ram_1p_adv: Width must be a multiple of DataBitsPerMask");
    end
    if (Depth < 2) begin : g_bad_depth
        $fatal(1, "prim_ram_1p_adv: Depth must be at least 2");
    end

    // Only the lowest mask bit of each lane matters; the rest and cfg_i are ignored.
    logic unused_inputs;
    assign unused_inputs = ^{cfg_i, wmask_i};

    logic [Lanes-1:0] lane_we;
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        lane_we = '0;
        for (int g = 0; g < Lanes; g++) begin
            lane_we[g] = wmask_i[g*DataBitsPerMask];
        end
    end

    // Array-stage request, either straight from the ports or one cycle delayed.
    logic             a_req;
    logic             a_write;
    logic [Aw-1:0]    a_addr;
    logic [Width-1:0] a_wdata;
    logic [Lanes-1:0] a_lane_we;

    if (EnableInputPipeline != 0) begin : g_in_pipe
        logic             req_q;
        logic             write_q;
        logic [Aw-1:0]    addr_q;
        logic [Width-1:0] wdata_q;
        logic [Lanes-1:0] lane_we_q;

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                req_q <= 1'b0;
            end else begin
                req_q <= req_i;
            end
        end

        always_ff @(posedge clk_i) begin
            if (req_i) begin
                write_q   <= write_i;
                addr_q    <= addr_i;
                wdata_q   <= wdata_i;
                lane_we_q <= lane_we;
            end
        end

        assign a_req     = req_q;
        assign a_write   = write_q;
        assign a_addr    = addr_q;
        assign a_wdata   = wdata_q;
        assign a_lane_we = lane_we_q;
    end else begin : g_in_bypass
        assign a_req     = req_i;
        assign a_write   = write_i;
        assign a_addr    = addr_i;
        assign a_wdata   = wdata_i;
        assign a_lane_we = lane_we;
    end

    logic addr_ok;
    assign addr_ok = {1'b0, a_addr} < DepthW;

    logic [Width-1:0] mem [Depth];

    // NOTE: the storage array has no reset; clearing it would turn the RAM into a flop bank.
    always_ff @(posedge clk_i) begin
        if (a_req && a_write && addr_ok) begin
            for (int g = 0; g < Lanes; g++) begin
                if (a_lane_we[g]) begin
                    mem[a_addr][g*DataBitsPerMask +: DataBitsPerMask] <=
                        a_wdata[g*DataBitsPerMask +: DataBitsPerMask];
                end
            end
        end
    end

    logic             rd_fire;
    logic [Width-1:0] rdata_a_d;
    logic [Width-1:0] rdata_a_q;
    logic             rvalid_a_q;

    assign rd_fire   = a_req && !a_write;
    assign rdata_a_d = addr_ok ? mem[a_addr] : '0;

    // Read data only changes on a completed read, so it holds between pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_a_q <= 1'b0;
            rdata_a_q  <= '0;
        end else begin
            rvalid_a_q <= rd_fire;
            if (rd_fire) begin
                rdata_a_q <= rdata_a_d;
            end
        end
    end

    if (EnableOutputPipeline != 0) begin : g_out_pipe
        logic             rvalid_q;
        logic [Width-1:0] rdata_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rvalid_a_q;
                if (rvalid_a_q) begin
                    rdata_q <= rdata_a_q;
                end
            end
        end

        assign rvalid_o = rvalid_q;
        assign rdata_o  = rdata_q;
    end else begin : g_out_bypass
        assign rvalid_o = rvalid_a_q;
        assign rdata_o  = rdata_a_q;
    end

    assign rerror_o = 2'b00;

endmodule

// File: tb/tb_prim_ram_1p_adv.sv
// Drives one shared stimulus stream into three RAM configurations (plain, fully pipelined,
// non-power-of-two depth) and checks each output stream against a per-instance scoreboard.
module tb_prim_ram_1p_adv;

    typedef struct {
        logic        req;
        logic        wr;
        logic [3:0]  addr;
        logic [63:0] wdata;
        logic [63:0] wmask;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    localparam logic [63:0] Ones = '1;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [3:0]  addr;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic [9:0]  cfg;

    logic [63:0] rdata [3];
    logic        rvalid [3];
    logic [1:0]  rerror [3];

    int          total;
    int          bad;
    int          cyc;
    exp_t        exp_q [3][$];
    logic [63:0] last [3];
    int          lat [3];
    vec_t        tbl [14];

    prim_ram_1p_adv #(
        .Depth(16), .Width(64), .DataBitsPerMask(32),
        .EnableInputPipeline(0), .EnableOutputPipeline(0)
    ) dut_plain (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .write_i(wr), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rdata[0]), .rvalid_o(rvalid[0]),
        .rerror_o(rerror[0]), .cfg_i(cfg)
    );

    prim_ram_1p_adv #(
        .Depth(16), .Width(64), .DataBitsPerMask(32),
        .EnableInputPipeline(1), .EnableOutputPipeline(1)
    ) dut_pipe (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .write_i(wr), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rdata[1]), .rvalid_o(rvalid[1]),
        .rerror_o(rerror[1]), .cfg_i(cfg)
    );

    prim_ram_1p_adv #(
        .Depth(12), .Width(64), .DataBitsPerMask(32),
        .EnableInputPipeline(0), .EnableOutputPipeline(0)
    ) dut_d12 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .write_i(wr), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rdata[2]), .rvalid_o(rvalid[2]),
        .rerror_o(rerror[2]), .cfg_i(cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, idx, cyc, act, exp);
        end
    endtask

    // Drives one request for a cycle; reads queue their expected word at each instance's latency.
    task automatic drive(input logic r, input logic w, input logic [3:0] a,
                         input logic [63:0] d, input logic [63:0] m, input logic [63:0] e);
        req   = r;
        wr    = w;
        addr  = a;
        wdata = d;
        wmask = m;
        cfg   = 10'($urandom);
        if (r && !w) begin
            for (int i = 0; i < 3; i++) begin
                exp_t it;
                it.data = (i == 2 && a >= 4'd12) ? 64'h0 : e;
                it.due  = cyc + lat[i];
                exp_q[i].push_back(it);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 4'd0, 64'h0, 64'h0, 64'h0);
    endtask

    task automatic monitor(input int i);
        check("rerror", i, {62'h0, rerror[i]}, 64'h0);
        if (rvalid[i] === 1'b1) begin
            if (exp_q[i].size() == 0 || exp_q[i][0].due != cyc) begin
                check("rvalid_unexpected", i, 64'h1, 64'h0);
            end else begin
                exp_t it;
                it = exp_q[i].pop_front();
                check("rdata", i, rdata[i], it.data);
                last[i] = it.data;
            end
        end else begin
            check("rdata_hold", i, rdata[i], last[i]);
            if (exp_q[i].size() > 0 && exp_q[i][0].due <= cyc) begin
                void'(exp_q[i].pop_front());
                check("rvalid_missing", i, {63'h0, rvalid[i]}, 64'h1);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) monitor(i);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        lat   = '{1, 3, 1};
        last  = '{64'h0, 64'h0, 64'h0};
        rst_n = 1'b0;
        req   = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        wmask = '0;
        cfg   = '0;

        tbl[0]  = '{1'b1, 1'b1, 4'd5,  64'hDEAD_BEEF_0123_4567, Ones,                  64'h0};
        tbl[1]  = '{1'b1, 1'b0, 4'd5,  64'h0,                  64'h0,                 64'hDEAD_BEEF_0123_4567};
        tbl[2]  = '{1'b1, 1'b1, 4'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 64'h0};
        tbl[3]  = '{1'b1, 1'b0, 4'd5,  64'h0,                  64'h0,                 64'hFFFF_FFFF_0123_4567};
        tbl[4]  = '{1'b1, 1'b1, 4'd5,  64'h0000_0000_AAAA_5555, 64'h0000_0000_0000_0001, 64'h0};
        tbl[5]  = '{1'b1, 1'b0, 4'd5,  64'h0,                  64'h0,                 64'hFFFF_FFFF_AAAA_5555};
        tbl[6]  = '{1'b1, 1'b1, 4'd5,  64'h1234_5678_0000_0000, 64'h0000_0001_FFFF_FFFE, 64'h0};
        tbl[7]  = '{1'b1, 1'b0, 4'd5,  64'h0,                  64'h0,                 64'h1234_5678_AAAA_5555};
        tbl[8]  = '{1'b1, 1'b1, 4'd3,  64'h1111_1111_1111_1111, Ones,                  64'h0};
        tbl[9]  = '{1'b1, 1'b1, 4'd3,  64'h0,                  64'h0,                 64'h0};
        tbl[10] = '{1'b0, 1'b0, 4'd3,  64'h0,                  64'h0,                 64'h0};
        tbl[11] = '{1'b1, 1'b0, 4'd3,  64'h0,                  64'h0,                 64'h1111_1111_1111_1111};
        tbl[12] = '{1'b1, 1'b1, 4'd13, 64'hCAFE_F00D_CAFE_F00D, Ones,                  64'h0};
        tbl[13] = '{1'b1, 1'b0, 4'd13, 64'h0,                  64'h0,                 64'hCAFE_F00D_CAFE_F00D};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_rdata", i, rdata[i], 64'h0);
            check("reset_rvalid", i, {63'h0, rvalid[i]}, 64'h0);
            check("reset_rerror", i, {62'h0, rerror[i]}, 64'h0);
        end
        rst_n = 1'b1;
        idle(2);

        for (int v = 0; v < 14; v++) begin
            drive(tbl[v].req, tbl[v].wr, tbl[v].addr, tbl[v].wdata, tbl[v].wmask, tbl[v].exp);
        end
        idle(5);

        for (int a = 0; a < 16; a++) drive(1'b1, 1'b1, 4'(a), 64'(a * 3), Ones, 64'h0);
        for (int a = 0; a < 16; a++) drive(1'b1, 1'b0, 4'(a), 64'h0, 64'h0, 64'(a * 3));
        idle(5);

        // Reset lands the cycle after a read is accepted; no instance may ever report it.
        drive(1'b1, 1'b0, 4'd5, 64'h0, 64'h0, 64'd15);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q[i].delete();
            last[i] = 64'h0;
        end
        idle(3);
        rst_n = 1'b1;
        idle(4);
        drive(1'b1, 1'b0, 4'd5, 64'h0, 64'h0, 64'd15);
        drive(1'b1, 1'b0, 4'd13, 64'h0, 64'h0, 64'd39);
        idle(6);

        for (int i = 0; i < 3; i++) begin
            check("drained", i, 64'(exp_q[i].size()), 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
